// File: rtl/ball_move_sched.sv
// Per-frame move scheduler for the bouncing balls: one decision per frame,
// with per-ball frame divisors and pause / single-step control.
module ball_move_sched #(
  parameter int         NBALL     = 4,
  parameter int         H_TRIG    = 640,
  parameter int         V_TRIG    = 480,
  parameter logic [3:0] DIV_RESET = 4'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pixpulse,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic             pause,
  input  logic             step_req,
  output logic             step_ack,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_idx,
  input  logic [3:0]       cfg_div,
  output logic [NBALL-1:0] move,
  output logic             frame_tick,
  output logic [15:0]      frame_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] FIRE = 2'd2;
  localparam logic [1:0] ACK  = 2'd3;

  logic [1:0]       state;
  logic [3:0]       div [NBALL];
  logic [3:0]       cnt [NBALL];
  logic [NBALL-1:0] fire;
  logic             step_pend;
  logic             step_frame;
  logic             trig;
  logic             go;

  assign trig = pixpulse
             && (hcount == 10'(H_TRIG))
             && (vcount == 10'(V_TRIG));

  assign go = trig && (!pause || step_pend);

  // move is combinational so a reset during FIRE drops it at once
  assign move     = (state == FIRE && pixpulse) ? fire : '0;
  assign step_ack = (state == ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_frame <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (go) state <= ARM;
        ARM: begin
          state      <= FIRE;
          step_frame <= step_pend;
        end
        FIRE: begin
          if (pixpulse)
            state <= step_frame ? ACK : IDLE;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // a pending step dies when the step completes or pause is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step_pend <= 1'b0;
    else if (state == ACK)
      step_pend <= 1'b0;
    else if (!pause)
      step_pend <= 1'b0;
    else if (step_req)
      step_pend <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_tick <= trig;
      if (state == ARM)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // a config write to a ball overrides its ARM-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire <= '0;
      for (int i = 0; i < NBALL; i++) begin
        div[i] <= DIV_RESET;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBALL; i++) begin
        if (cfg_we && int'(cfg_idx) == i) begin
          div[i] <= cfg_div;
          cnt[i] <= '0;
          if (state == ARM)
            fire[i] <= 1'b0;
        end else if (state == ARM) begin
          if (div[i] == 4'd0) begin
            fire[i] <= 1'b0;
          end else if (cnt[i] >= div[i] - 4'd1) begin
            fire[i] <= 1'b1;
            cnt[i]  <= '0;
          end else begin
            fire[i] <= 1'b0;
            cnt[i]  <= cnt[i] + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ball_move_sched.sv
// Directed frame-by-frame bench for ball_move_sched.
// Each table row is one frame: setup, trigger, then observed strobes.
module tb_ball_move_sched;

  localparam int         NB = 4;
  localparam logic [9:0] HT = 10'd640;
  localparam logic [9:0] VT = 10'd480;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pixpulse = 1'b0;
  logic [9:0]    hcount = '0;
  logic [9:0]    vcount = '0;
  logic          pause = 1'b0;
  logic          step_req = 1'b0;
  logic          step_ack;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_idx = '0;
  logic [3:0]    cfg_div = '0;
  logic [NB-1:0] move;
  logic          frame_tick;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int failures = 0;
  int ph = 0;

  always #5 clk = ~clk;

  ball_move_sched #(
    .NBALL(NB), .H_TRIG(640), .V_TRIG(480), .DIV_RESET(4'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse),
    .hcount(hcount), .vcount(vcount), .pause(pause),
    .step_req(step_req), .step_ack(step_ack),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_div(cfg_div),
    .move(move), .frame_tick(frame_tick), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int pz;
    int sreq;
    int wb;
    int wa;
    int wi;
    int wd;
    int mv;
    int ack;
    int fc;
  } vec_t;

  vec_t tv[23];

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    ph       = (ph + 1) & 3;
    pixpulse = (ph == 0);
    hcount   = '0;
    vcount   = '0;
    cfg_we   = 1'b0;
    step_req = 1'b0;
    #1;
  endtask

  task automatic run_frame(
    input  int wa, input int wi, input int wd, input int rst_at,
    output int mv, output int mv_off, output int moves,
    output int tick_off, output int ticks,
    output int ack_off, output int acks
  );
    mv = 0; mv_off = -1; moves = 0;
    tick_off = -1; ticks = 0; ack_off = -1; acks = 0;
    while (ph != 3) next_cycle();
    for (int off = 0; off < 10; off++) begin
      next_cycle();
      if (off == 0) begin
        hcount = HT;
        vcount = VT;
      end
      if (off == 1 && wa != 0) begin
        cfg_we  = 1'b1;
        cfg_idx = wi[2:0];
        cfg_div = wd[3:0];
      end
      if (off == rst_at) begin
        rst_n = 1'b0;
        #1;
      end
      if (move != '0) begin
        mv = int'(move);
        mv_off = off;
        moves++;
      end
      if (frame_tick) begin
        tick_off = off;
        ticks++;
      end
      if (step_ack) begin
        ack_off = off;
        acks++;
      end
    end
  endtask

  initial begin
    int mv, mv_off, moves, tick_off, ticks, ack_off, acks;

    //        pz sreq wb wa wi wd mv ack fc
    tv[0]  = '{0, 0, 0, 0, 0, 0, 15, 0, 1};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 15, 0, 2};
    tv[2]  = '{0, 0, 0, 0, 0, 0, 15, 0, 3};
    tv[3]  = '{0, 0, 1, 0, 2, 3, 11, 0, 4};
    tv[4]  = '{0, 0, 0, 0, 0, 0, 11, 0, 5};
    tv[5]  = '{0, 0, 0, 0, 0, 0, 15, 0, 6};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 11, 0, 7};
    tv[7]  = '{0, 0, 0, 0, 0, 0, 11, 0, 8};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 15, 0, 9};
    tv[9]  = '{0, 0, 1, 0, 1, 0,  9, 0, 10};
    tv[10] = '{0, 0, 0, 0, 0, 0,  9, 0, 11};
    tv[11] = '{0, 0, 0, 0, 0, 0, 13, 0, 12};
    tv[12] = '{0, 0, 0, 0, 0, 0,  9, 0, 13};
    tv[13] = '{0, 0, 0, 0, 0, 0,  9, 0, 14};
    tv[14] = '{1, 0, 0, 0, 0, 0,  0, 0, 14};
    tv[15] = '{1, 0, 0, 0, 0, 0,  0, 0, 14};
    tv[16] = '{1, 1, 0, 0, 0, 0, 13, 1, 15};
    tv[17] = '{1, 2, 0, 0, 0, 0,  9, 1, 16};
    tv[18] = '{1, 0, 0, 0, 0, 0,  0, 0, 16};
    tv[19] = '{0, 1, 0, 0, 0, 0,  9, 0, 17};
    tv[20] = '{1, 0, 0, 0, 0, 0,  0, 0, 17};
    tv[21] = '{0, 0, 0, 1, 0, 1, 12, 0, 18};
    tv[22] = '{0, 0, 0, 0, 0, 0,  9, 0, 19};

    #1;
    check("rst_move", int'(move), 0);
    check("rst_ack", int'(step_ack), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_fcnt", int'(frame_cnt), 0);
    repeat (3) next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();

    for (int k = 0; k < 23; k++) begin
      pause = tv[k].pz[0];
      next_cycle();
      for (int s = 0; s < tv[k].sreq; s++) begin
        step_req = 1'b1;
        next_cycle();
        next_cycle();
      end
      if (tv[k].wb != 0) begin
        cfg_we  = 1'b1;
        cfg_idx = tv[k].wi[2:0];
        cfg_div = tv[k].wd[3:0];
        next_cycle();
      end
      run_frame(tv[k].wa, tv[k].wi, tv[k].wd, -1,
                mv, mv_off, moves, tick_off, ticks, ack_off, acks);
      check($sformatf("f%0d_move", k), mv, tv[k].mv);
      check($sformatf("f%0d_moves", k), moves, (tv[k].mv != 0) ? 1 : 0);
      check($sformatf("f%0d_mvoff", k), mv_off, (tv[k].mv != 0) ? 4 : -1);
      check($sformatf("f%0d_ticks", k), ticks, 1);
      check($sformatf("f%0d_tickoff", k), tick_off, 1);
      check($sformatf("f%0d_acks", k), acks, tv[k].ack);
      check($sformatf("f%0d_ackoff", k), ack_off, (tv[k].ack != 0) ? 5 : -1);
      check($sformatf("f%0d_fcnt", k), int'(frame_cnt), tv[k].fc);
    end

    // pause dropped while a step is pending: no step, no ack
    pause = 1'b1;
    next_cycle();
    step_req = 1'b1;
    next_cycle();
    pause = 1'b0;
    next_cycle();
    pause = 1'b1;
    next_cycle();
    run_frame(0, 0, 0, -1,
              mv, mv_off, moves, tick_off, ticks, ack_off, acks);
    check("drop_moves", moves, 0);
    check("drop_acks", acks, 0);
    check("drop_fcnt", int'(frame_cnt), 19);

    // reset asserted mid-FIRE
    pause = 1'b0;
    next_cycle();
    run_frame(0, 0, 0, 2,
              mv, mv_off, moves, tick_off, ticks, ack_off, acks);
    check("rfire_moves", moves, 0);
    check("rfire_acks", acks, 0);
    check("rfire_fcnt", int'(frame_cnt), 0);
    check("rfire_tick", int'(frame_tick), 0);
    rst_n = 1'b1;
    repeat (2) next_cycle();

    run_frame(0, 0, 0, -1,
              mv, mv_off, moves, tick_off, ticks, ack_off, acks);
    check("post_move", mv, 15);
    check("post_mvoff", mv_off, 4);
    check("post_fcnt", int'(frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_move_sched.md
Name: ball_move_sched

Overview:
- Generates the per-ball `move` strobes for the bouncing-ball objects.
- Issues one scheduling decision per video frame, at a fixed raster position just past the visible area, after each ball's neighbour scan for the frame is complete.
- Each ball has a programmable frame divisor that sets its speed.
- Adds global pause and single-frame step control with a request/acknowledge handshake.

Parameters:
- NBALL, 4, number of ball instances served (1..8).
- H_TRIG, 640, hcount value at which the frame trigger fires.
- V_TRIG, 480, vcount value at which the frame trigger fires.
- DIV_RESET, 1, per-ball divisor loaded at reset (4-bit).

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- pixpulse  in  1  one-clk strobe every 4 clocks (25 MHz pixel rate)
- hcount  in  10  current raster x
- vcount  in  10  current raster y
- pause  in  1  level; 1 freezes all scheduling
- step_req  in  1  one-clk pulse; request one frame of motion while paused
- step_ack  out  1  one-clk pulse when the stepped frame's move strobe has been issued
- cfg_we  in  1  divisor write strobe
- cfg_idx  in  3  ball index for the write; idx >= NBALL is ignored
- cfg_div  in  4  divisor value; 0 = ball frozen
- move  out  NBALL  per-ball move strobe
- frame_tick  out  1  one-clk pulse on every detected trigger
- frame_cnt  out  16  count of frames processed, i.e. not paused or stepped

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE; move=0; step_ack=0; frame_tick=0; frame_cnt=0; all div[i]=DIV_RESET; all cnt[i]=0; step_pend=0.
- Trigger: a cycle with pixpulse=1, hcount==H_TRIG and vcount==V_TRIG. frame_tick=1 for exactly that clk, registered so it is visible the following cycle, regardless of pause.
- FSM states: IDLE, ARM, FIRE, ACK.
- IDLE -> ARM on trigger when (pause=0) or (pause=1 and step_pend=1). Otherwise the trigger is ignored: counters frozen, no move.
- ARM (1 clk): for each i:
  - if div[i]==0: fire[i]=0, cnt unchanged.
  - elif cnt[i] >= div[i]-1: fire[i]=1, cnt[i]<=0.
  - else: fire[i]=0, cnt[i]<=cnt[i]+1.
  - frame_cnt increments (wraps 0xFFFF->0).
  - Go to FIRE.
- FIRE: wait for the next pixpulse. In that exact clk, move[i]=fire[i]; move is 0 in every other cycle. The consumer samples move only when pixpulse=1, so move is asserted for exactly one pixpulse-qualified clk, 4 clks after the trigger. Then:
  - -> ACK if this frame was a step (step_pend=1 at ARM);
  - -> IDLE otherwise.
- ACK (1 clk): step_ack=1; step_pend<=0; -> IDLE.
- step_req:
  - sets step_pend only when pause=1 and step_pend=0.
  - ignored when pause=0 or when a step is already pending. No ack is produced for an ignored request.
  - Pause deasserting while step_pend=1 clears step_pend with no ack.
- cfg_we: div[idx]<=cfg_div and cnt[idx]<=0.
  - If cfg_we hits ball idx in the ARM cycle, the write wins: no fire for that ball that frame, and cnt ends at 0.
  - Writes are accepted in every state and during pause.
- A divisor of 1 moves the ball every frame; N moves it every N-th frame, and the first move occurs N frames after reset or a write.
- Triggers arriving while in ARM/FIRE/ACK are impossible by timing (one per frame). The FSM must nonetheless ignore them.
- Reset mid-FIRE: move goes low immediately (async); no strobe issued.

Test Plan:
- Reset, all div=1, run 3 frames -> move=4'b1111 once per frame, exactly in the pixpulse clk 4 clks after each trigger; frame_cnt=3.
- Write div[2]=3 after reset, run 6 frames -> move[2] high on frames 3 and 6 only; other balls every frame.
- cfg_div=0 to ball 1 -> move[1] never asserts over 5 frames; cnt[1] frozen.
- Set pause=1, run 2 frames -> no move, frame_cnt unchanged, frame_tick still pulses each trigger.
- Pulse step_req with pause=1 -> at the next trigger, move issued per counters, then step_ack=1 for 1 clk, frame_cnt+1. A second step_req while pending -> ignored.
- cfg_we to ball 0 in the ARM cycle with div=1 -> move[0]=0 that frame, fires next frame. Assert rst_n=0 mid-FIRE -> move=0 immediately, all state at reset values.
